// File: rtl/obi_mem_arbiter.sv
// obi_mem_arbiter: shares one OBI memory port between the instruction fetch
// unit and the load/store unit. The address phase is arbitrated. A master that
// wins but is not yet granted is locked in until its grant arrives. Every
// accepted transfer records its owner in an in-order route FIFO. That FIFO
// steers the response phase back to the owner.
//
// Optional build macro: OBI_ARB_RR_EN
//   defined   - round-robin between simultaneous unlocked requests
//   undefined - fixed priority, data over instr (no pointer register)
//
// Lock FSM states:
//   state     | meaning
//   ST_FREE   | no address phase pending, arbitration open
//   ST_LOCK_I | instr request issued but not granted, instr held as winner
//   ST_LOCK_D | data request issued but not granted, data held as winner
module obi_mem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_OUTST = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,

    input  logic                           instr_req_i,
    input  logic [ADDR_W-1:0]              instr_addr_i,
    output logic                           instr_gnt_o,
    output logic                           instr_rvalid_o,
    output logic [DATA_W-1:0]              instr_rdata_o,

    input  logic                           data_req_i,
    input  logic                           data_we_i,
    input  logic [DATA_W/8-1:0]            data_be_i,
    input  logic [ADDR_W-1:0]              data_addr_i,
    input  logic [DATA_W-1:0]              data_wdata_i,
    output logic                           data_gnt_o,
    output logic                           data_rvalid_o,
    output logic [DATA_W-1:0]              data_rdata_o,

    output logic                           mem_req_o,
    output logic                           mem_we_o,
    output logic [DATA_W/8-1:0]            mem_be_o,
    output logic [ADDR_W-1:0]              mem_addr_o,
    output logic [DATA_W-1:0]              mem_wdata_o,
    input  logic                           mem_gnt_i,
    input  logic                           mem_rvalid_i,
    input  logic [DATA_W-1:0]              mem_rdata_i,

    output logic [$clog2(MAX_OUTST+1)-1:0] outst_cnt_o,
    output logic                           err_o
);

    localparam int CNT_W = $clog2(MAX_OUTST + 1);
    localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int BE_W  = DATA_W / 8;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTST);

    typedef enum logic [1:0] {
        ST_FREE   = 2'd0,
        ST_LOCK_I = 2'd1,
        ST_LOCK_D = 2'd2
    } lock_state_e;

    lock_state_e state_q, state_d;

    logic [MAX_OUTST-1:0] route_q, route_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 err_q, err_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;

    logic win_data;
    logic win_req;
    logic accept;
    logic pop;
    logic head_data;

`ifdef OBI_ARB_RR_EN
    logic rr_data_q, rr_data_d;
`endif

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(MAX_OUTST - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    // Winner selection: a locked master keeps the port, otherwise arbitrate.
    always_comb begin
        win_data = 1'b0;
        unique case (state_q)
            ST_LOCK_I: win_data = 1'b0;
            ST_LOCK_D: win_data = 1'b1;
            default: begin
`ifdef OBI_ARB_RR_EN
                if (data_req_i && instr_req_i) begin
                    win_data = rr_data_q;
                end else begin
                    win_data = data_req_i;
                end
`else
                win_data = data_req_i;
`endif
            end
        endcase
    end

    assign win_req   = win_data ? data_req_i : instr_req_i;
    assign mem_req_o = rst_n && win_req && (cnt_q < MAX_CNT);
    assign accept    = mem_req_o && mem_gnt_i;

    assign instr_gnt_o = accept && !win_data;
    assign data_gnt_o  = accept && win_data;

    // Address-phase mux. Idle cycles keep the address bus quiet at its last value.
    always_comb begin
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_wdata_o = '0;
        mem_addr_o  = addr_q;
        if (mem_req_o) begin
            if (win_data) begin
                mem_we_o    = data_we_i;
                mem_be_o    = data_be_i;
                mem_wdata_o = data_wdata_i;
                mem_addr_o  = data_addr_i;
            end else begin
                mem_we_o    = 1'b0;
                mem_be_o    = {BE_W{1'b1}};
                mem_wdata_o = '0;
                mem_addr_o  = instr_addr_i;
            end
        end
    end

    // Response routing from the FIFO head. Read data goes to both ports.
    assign pop            = rst_n && mem_rvalid_i && (cnt_q != '0);
    assign head_data      = route_q[rd_ptr_q];
    assign instr_rvalid_o = pop && !head_data;
    assign data_rvalid_o  = pop && head_data;
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;

    assign outst_cnt_o = cnt_q;
    assign err_o       = err_q;

    // Lock FSM next state: lock on an ungranted issue, release on its grant.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_FREE: begin
                if (mem_req_o && !mem_gnt_i) begin
                    state_d = win_data ? ST_LOCK_D : ST_LOCK_I;
                end
            end
            ST_LOCK_I, ST_LOCK_D: begin
                if (accept) begin
                    state_d = ST_FREE;
                end
            end
            default: state_d = ST_FREE;
        endcase
    end

    // Route FIFO, in-flight counter, sticky error and address hold next state.
    always_comb begin
        route_d  = route_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        addr_d   = addr_q;

        if (mem_req_o) begin
            addr_d = mem_addr_o;
        end
        if (accept) begin
            route_d[wr_ptr_q] = win_data;
            wr_ptr_d          = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (accept && !pop) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!accept && pop) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        if (mem_rvalid_i && (cnt_q == '0)) begin
            err_d = 1'b1;
        end
    end

`ifdef OBI_ARB_RR_EN
    // The master just granted yields priority on the next tie.
    always_comb begin
        rr_data_d = rr_data_q;
        if (accept) begin
            rr_data_d = !win_data;
        end
    end

    // Round-robin pointer register, data favoured out of reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_data_q <= 1'b1;
        end else begin
            rr_data_q <= rr_data_d;
        end
    end
`endif

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_FREE;
            route_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            addr_q   <= '0;
        end else begin
            state_q  <= state_d;
            route_q  <= route_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            addr_q   <= addr_d;
        end
    end

endmodule

// File: tb/tb_obi_mem_arbiter.sv
// Bench for obi_mem_arbiter: directed scenarios plus randomized OBI traffic,
// checked each cycle against a queue-based reference model.
// Build with +define+OBI_ARB_RR_EN to exercise the round-robin variant.
module tb_obi_mem_arbiter;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int MAX_OUTST = 2;
    localparam int CNT_W     = $clog2(MAX_OUTST + 1);

    logic              clk = 1'b0;
    logic              rst_n;
    logic              instr_req_i;
    logic [ADDR_W-1:0] instr_addr_i;
    logic              instr_gnt_o, instr_rvalid_o;
    logic [DATA_W-1:0] instr_rdata_o;
    logic              data_req_i, data_we_i;
    logic [3:0]        data_be_i;
    logic [ADDR_W-1:0] data_addr_i;
    logic [DATA_W-1:0] data_wdata_i;
    logic              data_gnt_o, data_rvalid_o;
    logic [DATA_W-1:0] data_rdata_o;
    logic              mem_req_o, mem_we_o;
    logic [3:0]        mem_be_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic              mem_gnt_i, mem_rvalid_i;
    logic [DATA_W-1:0] mem_rdata_i;
    logic [CNT_W-1:0]  outst_cnt_o;
    logic              err_o;

    obi_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUTST(MAX_OUTST)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
        .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
        .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
        .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
        .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .outst_cnt_o(outst_cnt_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: owner queue (0=instr, 1=data), lock, last grant, error.
    int          route[$];
    bit          m_lock;
    bit          m_lock_data;
    bit          m_last_data;
    bit          m_err;
    bit          m_addr_vld;
    logic [31:0] m_last_addr;
    bit          e_igr, e_dgr;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Called with inputs set just after a negedge; checks all outputs against
    // the model, advances the model past the coming posedge, returns at the
    // next negedge.
    task automatic step();
        bit win_d, wreq, ereq, pop;
        #1;
        if (m_lock) begin
            win_d = m_lock_data;
        end else if (data_req_i && instr_req_i) begin
`ifdef OBI_ARB_RR_EN
            win_d = !m_last_data;
`else
            win_d = 1'b1;
`endif
        end else begin
            win_d = data_req_i;
        end
        wreq  = win_d ? data_req_i : instr_req_i;
        ereq  = rst_n && wreq && (route.size() < MAX_OUTST);
        e_igr = ereq && mem_gnt_i && !win_d;
        e_dgr = ereq && mem_gnt_i && win_d;
        pop   = rst_n && mem_rvalid_i && (route.size() > 0);

        check_val("mem_req", mem_req_o, ereq);
        check_val("instr_gnt", instr_gnt_o, e_igr);
        check_val("data_gnt", data_gnt_o, e_dgr);
        check_val("instr_rvalid", instr_rvalid_o, pop && route[0] == 0);
        check_val("data_rvalid", data_rvalid_o, pop && route[0] == 1);
        check_val("instr_rdata", instr_rdata_o, mem_rdata_i);
        check_val("data_rdata", data_rdata_o, mem_rdata_i);
        check_val("outst_cnt", outst_cnt_o, route.size());
        check_val("err", err_o, m_err);
        if (ereq) begin
            check_val("mem_addr", mem_addr_o, win_d ? data_addr_i : instr_addr_i);
            check_val("mem_we", mem_we_o, win_d ? data_we_i : 1'b0);
            check_val("mem_be", mem_be_o, win_d ? data_be_i : 4'hF);
            check_val("mem_wdata", mem_wdata_o, win_d ? data_wdata_i : 32'h0);
        end else begin
            check_val("idle_we", mem_we_o, 1'b0);
            check_val("idle_be", mem_be_o, 4'h0);
            check_val("idle_wdata", mem_wdata_o, 32'h0);
            if (m_addr_vld) check_val("idle_addr_hold", mem_addr_o, m_last_addr);
        end

        if (!rst_n) begin
            route.delete();
            m_lock      = 1'b0;
            m_err       = 1'b0;
            m_last_data = 1'b0;
            m_addr_vld  = 1'b0;
        end else begin
            if (mem_rvalid_i && route.size() == 0) m_err = 1'b1;
            if (pop) void'(route.pop_front());
            if (ereq) begin
                m_last_addr = win_d ? data_addr_i : instr_addr_i;
                m_addr_vld  = 1'b1;
                if (mem_gnt_i) begin
                    route.push_back(int'(win_d));
                    m_last_data = win_d;
                    m_lock      = 1'b0;
                end else begin
                    m_lock      = 1'b1;
                    m_lock_data = win_d;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        instr_req_i  = 1'b0;
        data_req_i   = 1'b0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && route.size() > 0; k++) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = $urandom;
            step();
        end
        mem_rvalid_i = 1'b0;
        check_val("drain_empty", outst_cnt_o, 0);
    endtask

    bit i_pend, d_pend;

    initial begin
        rst_n        = 1'b0;
        instr_addr_i = '0;
        data_addr_i  = '0;
        data_we_i    = 1'b0;
        data_be_i    = 4'hF;
        data_wdata_i = '0;
        mem_rdata_i  = '0;
        idle_inputs();
        @(negedge clk);
        step();
        step();
        rst_n = 1'b1;
        #1;
        check_val("rst_cnt", outst_cnt_o, 0);
        check_val("rst_err", err_o, 0);
        check_val("rst_req", mem_req_o, 0);
        step();

        // Simultaneous requests: data first, then instr.
        instr_req_i = 1'b1; instr_addr_i = 32'h100;
        data_req_i  = 1'b1; data_addr_i  = 32'h200;
        data_we_i   = 1'b0; data_be_i    = 4'hF;
        mem_gnt_i   = 1'b1;
        #1;
        check_val("sim_data_gnt", data_gnt_o, 1);
        check_val("sim_instr_gnt0", instr_gnt_o, 0);
        check_val("sim_addr_d", mem_addr_o, 32'h200);
        step();
        data_req_i = 1'b0;
        #1;
        check_val("sim_instr_gnt", instr_gnt_o, 1);
        check_val("sim_addr_i", mem_addr_o, 32'h100);
        step();
        idle_inputs();
        drain();

        // Response routing: instr then data.
        instr_req_i = 1'b1; instr_addr_i = 32'h40; mem_gnt_i = 1'b1;
        step();
        instr_req_i = 1'b0;
        data_req_i  = 1'b1; data_addr_i = 32'h80; data_we_i = 1'b1; data_wdata_i = 32'h1234;
        step();
        idle_inputs();
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hAAAA;
        #1;
        check_val("route_i_rv", instr_rvalid_o, 1);
        check_val("route_i_data", instr_rdata_o, 32'hAAAA);
        check_val("route_i_drv0", data_rvalid_o, 0);
        step();
        mem_rdata_i = 32'hBBBB;
        #1;
        check_val("route_d_rv", data_rvalid_o, 1);
        check_val("route_d_data", data_rdata_o, 32'hBBBB);
        check_val("route_d_irv0", instr_rvalid_o, 0);
        step();
        mem_rvalid_i = 1'b0;

        // Grant stall: instr locked in, data arrives mid-stall.
        data_we_i = 1'b0;
        instr_req_i = 1'b1; instr_addr_i = 32'h300; mem_gnt_i = 1'b0;
        step();
        data_req_i = 1'b1; data_addr_i = 32'h400;
        for (int k = 0; k < 2; k++) begin
            #1;
            check_val("stall_addr", mem_addr_o, 32'h300);
            check_val("stall_dgnt", data_gnt_o, 0);
            step();
        end
        mem_gnt_i = 1'b1;
        #1;
        check_val("stall_igrant", instr_gnt_o, 1);
        step();
        instr_req_i = 1'b0;
        #1;
        check_val("stall_dgrant", data_gnt_o, 1);
        check_val("stall_daddr", mem_addr_o, 32'h400);
        step();
        idle_inputs();
        drain();

        // Back-to-back until full, then one response reopens issue.
        instr_req_i = 1'b1; mem_gnt_i = 1'b1;
        instr_addr_i = 32'h500; step();
        instr_addr_i = 32'h504; step();
        instr_addr_i = 32'h508;
        #1;
        check_val("full_req", mem_req_o, 0);
        check_val("full_cnt", outst_cnt_o, 2);
        step();
        mem_rvalid_i = 1'b1;
        #1;
        check_val("full_pop_req", mem_req_o, 0);
        step();
        mem_rvalid_i = 1'b0;
        #1;
        check_val("full_resume", instr_gnt_o, 1);
        step();
        idle_inputs();
        drain();

        // Randomized traffic obeying OBI request stability.
        i_pend = 1'b0;
        d_pend = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (!i_pend) begin
                instr_req_i  = ($urandom_range(0, 99) < 45);
                instr_addr_i = $urandom & 32'hFFFF_FFFC;
            end
            if (!d_pend) begin
                data_req_i   = ($urandom_range(0, 99) < 45);
                data_addr_i  = $urandom;
                data_we_i    = $urandom_range(0, 1);
                data_be_i    = 4'($urandom_range(0, 15));
                data_wdata_i = $urandom;
            end
            mem_gnt_i    = ($urandom_range(0, 99) < 70);
            mem_rvalid_i = (route.size() > 0) && ($urandom_range(0, 99) < 50);
            mem_rdata_i  = $urandom;
            step();
            i_pend = instr_req_i && !e_igr;
            d_pend = data_req_i && !e_dgr;
        end
        // Let pending requests complete, then drain.
        mem_gnt_i = 1'b1;
        for (int k = 0; k < 10 && (i_pend || d_pend); k++) begin
            mem_rvalid_i = (route.size() > 0);
            step();
            i_pend = i_pend && !e_igr;
            d_pend = d_pend && !e_dgr;
            if (!i_pend) instr_req_i = 1'b0;
            if (!d_pend) data_req_i = 1'b0;
        end
        check_val("rand_pending_done", {i_pend, d_pend}, 2'b00);
        idle_inputs();
        drain();

        // Spurious response with an empty FIFO.
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD;
        #1;
        check_val("spur_irv", instr_rvalid_o, 0);
        check_val("spur_drv", data_rvalid_o, 0);
        step();
        mem_rvalid_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_val("spur_err_sticky", err_o, 1);
            step();
        end

        // Reset mid-transfer with one outstanding and a data lock pending.
        instr_req_i = 1'b1; instr_addr_i = 32'h600; mem_gnt_i = 1'b1;
        step();
        instr_req_i = 1'b0;
        data_req_i = 1'b1; data_addr_i = 32'h700; mem_gnt_i = 1'b0;
        step();
        rst_n = 1'b0; instr_req_i = 1'b1;
        #1;
        check_val("rst_mid_req", mem_req_o, 0);
        check_val("rst_mid_dgnt", data_gnt_o, 0);
        step();
        rst_n = 1'b1; data_req_i = 1'b0;
        #1;
        check_val("rst_mid_cnt", outst_cnt_o, 0);
        check_val("rst_mid_err", err_o, 0);
        check_val("rst_mid_unlock", mem_req_o, 1);
        check_val("rst_mid_addr", mem_addr_o, 32'h600);
        step();
        idle_inputs();
        mem_rvalid_i = 1'b1;
        step();
        mem_rvalid_i = 1'b0;
        #1;
        check_val("late_resp_err", err_o, 1);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
